spi_audio_tx: RTL and testbench



---
 rtl/spi_audio_tx.sv | 153 +++++++++++++++
 tb/tb_spi_audio_tx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/spi_audio_tx.sv
// SPI mode-0 master that serialises 16-bit audio samples to the DAC, MSB first,
// with a one-entry holding buffer in front of the shift register.
module spi_audio_tx #(
  parameter int clock_max = 25_000_000,
  parameter int SCLK_DIV  = 2
) (
  input  logic        clk_25mhz,
  input  logic        reset,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun,
  output logic        dac_cs_n,
  output logic        dac_sclk,
  output logic        dac_mosi
);

  if (SCLK_DIV < 1) begin : g_bad_div
    $error("spi_audio_tx: SCLK_DIV must be >= 1");
  end
  if (clock_max <= 0) begin : g_bad_clk
    $error("spi_audio_tx: clock_max must be positive");
  end

  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, LOW, HIGH, HOLD, GAP} state_t;

  state_t        state, state_nxt;
  logic [15:0]   hold, hold_nxt, shift_reg, shift_nxt;
  logic          hold_full, hold_full_nxt;
  logic [3:0]    bit_cnt, bit_nxt;
  logic [DW-1:0] div_cnt, div_nxt;
  logic          cs_nxt, sclk_nxt, mosi_nxt, done_nxt, ovr_nxt;
  logic          load_now, accept, div_end;

  assign load_now     = (state == IDLE) && hold_full;
  assign sample_ready = !hold_full || load_now;
  assign busy         = (state != IDLE);
  assign accept       = sample_valid && sample_ready;
  assign div_end      = (div_cnt == DIV_LAST);

  always_comb begin
    state_nxt     = state;
    hold_nxt      = hold;
    hold_full_nxt = hold_full;
    shift_nxt     = shift_reg;
    bit_nxt       = bit_cnt;
    div_nxt       = div_cnt;
    cs_nxt        = dac_cs_n;
    sclk_nxt      = dac_sclk;
    mosi_nxt      = dac_mosi;
    done_nxt      = 1'b0;
    ovr_nxt       = sample_valid && !sample_ready;

    // A write in the load cycle wins, so the buffer stays full with new data.
    if (load_now) hold_full_nxt = 1'b0;
    if (accept) begin
      hold_nxt      = sample_in;
      hold_full_nxt = 1'b1;
    end

    case (state)
      IDLE: begin
        if (load_now) begin
          shift_nxt = hold;
          cs_nxt    = 1'b0;
          mosi_nxt  = hold[15];
          bit_nxt   = '0;
          div_nxt   = '0;
          state_nxt = LOW;
        end
      end
      LOW: begin
        if (div_end) begin
          div_nxt   = '0;
          sclk_nxt  = 1'b1;
          state_nxt = HIGH;
        end else begin
          div_nxt = div_cnt + DW'(1);
        end
      end
      HIGH: begin
        if (div_end) begin
          div_nxt  = '0;
          sclk_nxt = 1'b0;
          if (bit_cnt != 4'd15) begin
            shift_nxt = {shift_reg[14:0], 1'b0};
            mosi_nxt  = shift_reg[14];
            bit_nxt   = bit_cnt + 4'd1;
            state_nxt = LOW;
          end else begin
            state_nxt = HOLD;
          end
        end else begin
          div_nxt = div_cnt + DW'(1);
        end
      end
      HOLD: begin
        if (div_end) begin
          div_nxt   = '0;
          cs_nxt    = 1'b1;
          done_nxt  = 1'b1;
          mosi_nxt  = 1'b0;
          state_nxt = GAP;
        end else begin
          div_nxt = div_cnt + DW'(1);
        end
      end
      GAP: begin
        if (div_end) begin
          div_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          div_nxt = div_cnt + DW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      hold       <= '0;
      hold_full  <= 1'b0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      dac_cs_n   <= 1'b1;
      dac_sclk   <= 1'b0;
      dac_mosi   <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_nxt;
      hold       <= hold_nxt;
      hold_full  <= hold_full_nxt;
      shift_reg  <= shift_nxt;
      bit_cnt    <= bit_nxt;
      div_cnt    <= div_nxt;
      dac_cs_n   <= cs_nxt;
      dac_sclk   <= sclk_nxt;
      dac_mosi   <= mosi_nxt;
      frame_done <= done_nxt;
      overrun    <= ovr_nxt;
    end
  end

endmodule

// File: tb/tb_spi_audio_tx.sv
// Bench for spi_audio_tx: two instances (SCLK_DIV=2 and 1) with an SPI receiver
// model and a queue of expected frames per instance.
module tb_spi_audio_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  sv = '0;
  logic [15:0] sd [2];
  logic [1:0]  ready_v, busy_v, fd_v, ovr_v, cs_v, sclk_v, mosi_v;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [15:0] q0 [$];
  logic [15:0] q1 [$];

  int          edges [2], low_len [2], high_len [2], frames [2], ovr_cnt [2];
  int          period [2], last_fall [2];
  bit          in_frame [2], had_fall [2];
  logic [15:0] rx [2];
  logic        prev_cs [2], prev_sclk [2], prev_mosi [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  spi_audio_tx #(.clock_max(25_000_000), .SCLK_DIV(2)) dut0 (
    .clk_25mhz(clk), .reset(rst), .sample_in(sd[0]), .sample_valid(sv[0]),
    .sample_ready(ready_v[0]), .busy(busy_v[0]), .frame_done(fd_v[0]),
    .overrun(ovr_v[0]), .dac_cs_n(cs_v[0]), .dac_sclk(sclk_v[0]), .dac_mosi(mosi_v[0])
  );

  spi_audio_tx #(.clock_max(25_000_000), .SCLK_DIV(1)) dut1 (
    .clk_25mhz(clk), .reset(rst), .sample_in(sd[1]), .sample_valid(sv[1]),
    .sample_ready(ready_v[1]), .busy(busy_v[1]), .frame_done(fd_v[1]),
    .overrun(ovr_v[1]), .dac_cs_n(cs_v[1]), .dac_sclk(sclk_v[1]), .dac_mosi(mosi_v[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Receiver model: samples MOSI on SCLK rising edges while CS is low.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        in_frame[i] = 1'b0;
        prev_cs[i] = 1'b1; prev_sclk[i] = 1'b0; prev_mosi[i] = 1'b0;
      end else begin
        logic [31:0] expv;
        int div;
        div = (i == 0) ? 2 : 1;
        if (ovr_v[i]) ovr_cnt[i]++;
        if (prev_cs[i] && !cs_v[i]) begin
          if (had_fall[i]) begin
            period[i] = cyc - last_fall[i];
            check("gap_min", {31'b0, high_len[i] >= 1}, 32'd1);
          end
          had_fall[i] = 1'b1;
          last_fall[i] = cyc;
          in_frame[i] = 1'b1; edges[i] = 0; low_len[i] = 1; rx[i] = '0;
        end else if (in_frame[i] && !prev_cs[i] && !cs_v[i]) begin
          low_len[i]++;
          if (!prev_sclk[i] && sclk_v[i]) begin
            rx[i] = {rx[i][14:0], mosi_v[i]};
            edges[i]++;
          end
          if (mosi_v[i] !== prev_mosi[i])
            check("mosi_on_fall", {31'b0, prev_sclk[i] & ~sclk_v[i]}, 32'd1);
        end
        if (cs_v[i]) high_len[i]++;
        if (in_frame[i] && !prev_cs[i] && cs_v[i]) begin
          expv = 32'hFFFF_FFFF;
          if (i == 0 && q0.size() > 0) expv = {16'b0, q0.pop_front()};
          if (i == 1 && q1.size() > 0) expv = {16'b0, q1.pop_front()};
          check("frame_data", {16'b0, rx[i]}, expv);
          check("sclk_edges", edges[i], 32'd16);
          check("cs_low_len", low_len[i], 33 * div);
          check("frame_done_at_rise", {31'b0, fd_v[i]}, 32'd1);
          in_frame[i] = 1'b0; high_len[i] = 1; frames[i]++;
        end else if (fd_v[i]) begin
          check("frame_done_spurious", {31'b0, fd_v[i]}, 32'd0);
        end
        prev_cs[i] = cs_v[i]; prev_sclk[i] = sclk_v[i]; prev_mosi[i] = mosi_v[i];
      end
    end
  end

  // Called at a negedge; drives a one-cycle strobe and returns at the next negedge.
  task automatic strobe(input int i, input logic [15:0] d, input bit push);
    sv[i] = 1'b1;
    sd[i] = d;
    if (push) begin
      if (i == 0) q0.push_back(d); else q1.push_back(d);
    end
    @(negedge clk);
    sv[i] = 1'b0;
  endtask

  task automatic wait_frames(input int i, input int n);
    for (int k = 0; k < 3000 && frames[i] < n; k++) @(negedge clk);
    check("frame_timeout", {31'b0, frames[i] >= n}, 32'd1);
    for (int k = 0; k < 100 && busy_v[i]; k++) @(negedge clk);
    check("idle_timeout", {31'b0, busy_v[i]}, 32'd0);
  endtask

  initial begin
    int f, o;
    sd[0] = '0; sd[1] = '0;
    for (int i = 0; i < 2; i++) begin
      edges[i] = 0; low_len[i] = 0; high_len[i] = 0; frames[i] = 0; ovr_cnt[i] = 0;
      period[i] = 0; last_fall[i] = 0; in_frame[i] = 0; had_fall[i] = 0; rx[i] = '0;
      prev_cs[i] = 1'b1; prev_sclk[i] = 1'b0; prev_mosi[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("rst_cs_n", {31'b0, cs_v[0]}, 32'd1);
    check("rst_sclk", {31'b0, sclk_v[0]}, 32'd0);
    check("rst_mosi", {31'b0, mosi_v[0]}, 32'd0);
    check("rst_flags", {28'b0, busy_v[0], fd_v[0], ovr_v[0], ready_v[0]}, 32'd1);
    check("rst_cs_n_div1", {31'b0, cs_v[1]}, 32'd1);
    #2 rst = 1'b0;
    @(negedge clk);

    // Single frame, latency from strobe to CS fall.
    strobe(0, 16'hA5C3, 1);
    check("latency_n1_cs_high", {31'b0, cs_v[0]}, 32'd1);
    @(negedge clk);
    check("latency_n2_cs_low", {31'b0, cs_v[0]}, 32'd0);
    wait_frames(0, 1);

    // Queued second sample, minimum frame period.
    f = frames[0]; o = ovr_cnt[0];
    strobe(0, 16'h1234, 1);
    repeat (9) @(negedge clk);
    strobe(0, 16'hFEDC, 1);
    check("ready_while_queued", {31'b0, ready_v[0]}, 32'd0);
    wait_frames(0, f + 2);
    check("frame_period", period[0], 32'd69);
    check("no_overrun_queued", ovr_cnt[0], o);

    // Third strobe within a frame is dropped.
    f = frames[0]; o = ovr_cnt[0];
    strobe(0, 16'h0001, 1);
    repeat (5) @(negedge clk);
    strobe(0, 16'h0002, 1);
    repeat (5) @(negedge clk);
    strobe(0, 16'h0003, 0);
    repeat (3) @(negedge clk);
    check("overrun_single", ovr_cnt[0], o + 1);
    wait_frames(0, f + 2);
    check("overrun_total", ovr_cnt[0], o + 1);

    // Reset while bit 7 is on the wire.
    strobe(0, 16'h5A5A, 1);
    for (int k = 0; k < 500 && !(in_frame[0] && edges[0] == 8 && !sclk_v[0]); k++)
      @(negedge clk);
    check("reach_bit7", edges[0], 32'd8);
    f = frames[0];
    #2 rst = 1'b1;
    #1;
    check("abort_cs_n", {31'b0, cs_v[0]}, 32'd1);
    check("abort_sclk", {31'b0, sclk_v[0]}, 32'd0);
    check("abort_busy_fd", {30'b0, busy_v[0], fd_v[0]}, 32'd0);
    q0.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("abort_no_frame", frames[0], f);
    strobe(0, 16'h8000, 1);
    wait_frames(0, f + 1);

    // SCLK_DIV=1 back-to-back extremes, second strobe on the load cycle.
    o = ovr_cnt[1];
    strobe(1, 16'h0000, 1);
    strobe(1, 16'hFFFF, 1);
    wait_frames(1, 2);
    check("div1_period", period[1], 32'd35);
    check("div1_no_overrun", ovr_cnt[1], o);

    // Strobe coinciding with load_now on SCLK_DIV=2.
    f = frames[0]; o = ovr_cnt[0];
    strobe(0, 16'h3C3C, 1);
    check("ready_on_load", {31'b0, ready_v[0]}, 32'd1);
    strobe(0, 16'hC3C3, 1);
    wait_frames(0, f + 2);
    check("load_collide_no_overrun", ovr_cnt[0], o);

    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
